clk_div_gen: RTL and testbench
==============================

# clk_div_gen

Synthesizable, multi-channel successor to the behavioural clock generator: derives NUM_CH independent divided clocks from one system clock, each with runtime-programmable period, high time (duty) and phase offset. Start and stop are glitch-free: pulses are never truncated, and configuration changes take effect only on period boundaries. The block sits in the CPU clocking area and feeds peripheral and test clocks.

## Interface
- NUM_CH, 4: number of independent output channels (1..16).
- DIV_W, 8: width of the divisor, high-time and phase fields.
- DEF_DIV, 4: reset period of every channel, in clk cycles (2..2^DIV_W-1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  NUM_CH  per-channel run request (level, synchronous to clk).
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  configuration can be accepted for channel cfg_ch.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_div  in  DIV_W  period P, in cycles.
- cfg_high  in  DIV_W  high time H, in cycles.
- cfg_phase  in  DIV_W  start delay D, in cycles.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- clk_out  out  NUM_CH  registered divided clocks.
- tick  out  NUM_CH  one-cycle pulse on each rising edge of clk_out[i].
- busy  out  NUM_CH  channel not IDLE.

## Operation
- Per-channel FSM: IDLE, PHASE, RUN, STOP. Counter cnt runs 0..P-1.
- IDLE + enable=1: if D==0, go to RUN with cnt=0. Otherwise go to PHASE and load a delay counter with D-1.
- PHASE: decrement; at 0, go to RUN with cnt=0. If enable drops during PHASE, return to IDLE; no pulse is emitted.
- RUN: clk_out = (cnt < H); cnt wraps P-1 -> 0. tick=1 whenever cnt==0 is entered.
- RUN + enable=0: go to STOP. The current period completes.
- STOP at cnt==P-1: go to IDLE, clk_out=0. If enable re-asserts while in STOP, return to RUN without a gap.
- Config write is accepted when cfg_valid && cfg_ready. Validity rule: P>=2, 1<=H<=P-1, D<=P-1.
  - Invalid write: pulse cfg_err; no state changes.
  - Valid write to an IDLE channel: applies immediately.
  - Valid write otherwise: held in a shadow register and applied at the next cnt==P-1 -> 0 wrap. It is discarded if the channel reaches IDLE first, where the shadow applies instead.
- cfg_ready = !pending[cfg_ch]. An out-of-range cfg_ch is invalid (cfg_err).
- Arithmetic: all compares are unsigned DIV_W-bit. No carry-out.

## Timing
- Reset values:
  - clk_out, tick, busy, cfg_err = 0; cfg_ready = 1.
  - All channels IDLE, P=DEF_DIV, H=DEF_DIV/2, D=0, no pending update.
- Start latency: enable sampled high at edge k -> clk_out/tick high after edge k+1+D.
- Output pattern: clk_out is high H cycles, then low P-H cycles, repeating.
- Stop: the final low phase always completes. busy falls with the edge that ends the last period.
- cfg_err is asserted the cycle after the rejected write.
- Reset asserted mid-operation: outputs drop to their reset values immediately (asynchronously). Pending configuration is lost.

## Configuration
- CLK_DIV_GEN_PHASE_EN defined: PHASE state and delay counter present; cfg_phase is honoured and validated.
- Not defined: cfg_phase is ignored and not validated; IDLE goes straight to RUN. The port remains for a stable interface.

## Structure
- Package clk_div_gen_pkg holds:
  - the state enum (IDLE/PHASE/RUN/STOP);
  - a channel config struct {div, high, phase};
  - the validation function.
- Sub-module clk_div_gen_ch implements one channel: FSM, counters, shadow register. The top module instantiates NUM_CH copies and decodes cfg.

## Test plan
- Reset defaults, enable[0]=1 (DEF_DIV=4): clk_out[0] follows 1100 repeating, starting 1 cycle after enable; tick every 4 cycles.
- Write ch1 P=5, H=1, D=2, then enable[1]=1 at edge k: first rise after edge k+3; pattern 10000; tick aligned to each rise.
- Drop enable[0] during a high phase: the high phase and the low phase complete; busy[0] falls at the period end. No pulse shorter than H.
- While ch0 is running with P=4, write P=6, H=3: cfg_ready falls; the old period finishes; the next period is 111000; cfg_ready recovers.
- Write H=0, H=P, and P=1: cfg_err pulses each time; outputs unchanged.
- Assert rst_n low mid-high on all channels: clk_out=0 immediately. After release, a channel with enable still high restarts with default settings.

Source files
------------

// File: rtl/clk_div_gen_pkg.sv
// clk_div_gen_pkg: channel state, channel config bundle and config check.
// CLK_DIV_GEN_PHASE_EN: when defined, the start delay (phase) is honoured.
package clk_div_gen_pkg;

   localparam int CFG_W = 8;

`ifdef CLK_DIV_GEN_PHASE_EN
   localparam bit PHASE_EN = 1'b1;
`else
   localparam bit PHASE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      PHASE,
      RUN,
      STOP
   } ch_state_e;

   typedef struct packed {
      logic [CFG_W-1:0] div;
      logic [CFG_W-1:0] high;
      logic [CFG_W-1:0] phase;
   } ch_cfg_t;

   // P >= 2, 1 <= H <= P-1, and D <= P-1 only when the delay exists.
   function automatic logic cfg_is_valid(input ch_cfg_t c);
      logic ok;
      ok = (c.div >= CFG_W'(2))
         && (c.high != '0)
         && (c.high < c.div);
      if (PHASE_EN) begin
         ok = ok && (c.phase < c.div);
      end
      return ok;
   endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// clk_div_gen_if: run requests, config write port and divided clocks.
// master drives enable/cfg_*; slave (the divider) drives the rest.
interface clk_div_gen_if #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 8
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] enable;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic [DIV_W-1:0]  cfg_high;
   logic [DIV_W-1:0]  cfg_phase;
   logic              cfg_err;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] busy;

   modport master (
      output enable, cfg_valid, cfg_ch,
      output cfg_div, cfg_high, cfg_phase,
      input  cfg_ready, cfg_err,
      input  clk_out, tick, busy
   );

   modport slave (
      input  enable, cfg_valid, cfg_ch,
      input  cfg_div, cfg_high, cfg_phase,
      output cfg_ready, cfg_err,
      output clk_out, tick, busy
   );

endinterface

// File: rtl/clk_div_gen_ch.sv
// clk_div_gen_ch: one divided-clock channel (FSM, counters, shadow cfg).
// Ports: en run request, wr_en/wr_cfg validated write, pending shadow
// full, clk_out/tick/busy registered outputs. Macro: CLK_DIV_GEN_PHASE_EN.
module clk_div_gen_ch
   import clk_div_gen_pkg::*;
#(
   parameter int DEF_DIV = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    en,
   input  logic    wr_en,
   input  ch_cfg_t wr_cfg,
   output logic    pending,
   output logic    clk_out,
   output logic    tick,
   output logic    busy
);

   localparam ch_cfg_t RST_CFG = '{
      div:   CFG_W'(DEF_DIV),
      high:  CFG_W'(DEF_DIV / 2),
      phase: '0
   };

   ch_state_e        state_q, state_d;
   logic [CFG_W-1:0] cnt_q, cnt_d;
   ch_cfg_t          cfg_q, cfg_d;
   ch_cfg_t          shd_q, shd_d;
   logic             pend_q, pend_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             busy_q, busy_d;

`ifdef CLK_DIV_GEN_PHASE_EN
   logic [CFG_W-1:0] dly_q, dly_d;
`else
   logic unused_phase;
   assign unused_phase = ^{cfg_q.phase, shd_q.phase};
`endif

   logic    last;
   logic    run;
   logic    idle_wr;
   logic    at_bound;
   ch_cfg_t start_cfg;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cfg_d     = cfg_q;
      shd_d     = shd_q;
      pend_d    = pend_q;
`ifdef CLK_DIV_GEN_PHASE_EN
      dly_d     = dly_q;
`endif
      run       = (state_q == RUN) || (state_q == STOP);
      last      = (cnt_q == (cfg_q.div - CFG_W'(1)));
      idle_wr   = wr_en && (state_q == IDLE);
      // A write landing on an idle channel also governs this start.
      start_cfg = idle_wr ? wr_cfg : cfg_q;

      if (idle_wr) begin
         cfg_d = wr_cfg;
      end else if (wr_en) begin
         shd_d  = wr_cfg;
         pend_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (en) begin
`ifdef CLK_DIV_GEN_PHASE_EN
               if (start_cfg.phase == '0) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  state_d = PHASE;
                  dly_d   = start_cfg.phase - CFG_W'(1);
               end
`else
               state_d = RUN;
               cnt_d   = '0;
`endif
            end
         end
         PHASE: begin
`ifdef CLK_DIV_GEN_PHASE_EN
            if (!en) begin
               state_d = IDLE;
            end else if (dly_q == '0) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               dly_d = dly_q - CFG_W'(1);
            end
`else
            state_d = IDLE;
`endif
         end
         RUN, STOP: begin
            cnt_d = last ? '0 : cnt_q + CFG_W'(1);
            // Never cut a period short: leave only at its last cycle.
            if (en) begin
               state_d = RUN;
            end else if (last) begin
               state_d = IDLE;
            end else begin
               state_d = STOP;
            end
         end
         default: state_d = IDLE;
      endcase

      // Period boundary, or leaving PHASE for IDLE: shadow takes over.
      at_bound = (run && last)
         || ((state_q == PHASE) && (state_d == IDLE));
      if (at_bound && wr_en) begin
         cfg_d  = wr_cfg;
         pend_d = 1'b0;
      end else if (at_bound && pend_q) begin
         cfg_d  = shd_q;
         pend_d = 1'b0;
      end

      // Outputs trail cnt by one edge, so busy trails state likewise.
      clk_out_d = run && (cnt_q < cfg_q.high);
      tick_d    = run && (cnt_q == '0);
      busy_d    = (state_q != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         cfg_q     <= RST_CFG;
         shd_q     <= RST_CFG;
         pend_q    <= 1'b0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef CLK_DIV_GEN_PHASE_EN
         dly_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cfg_q     <= cfg_d;
         shd_q     <= shd_d;
         pend_q    <= pend_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         busy_q    <= busy_d;
`ifdef CLK_DIV_GEN_PHASE_EN
         dly_q     <= dly_d;
`endif
      end
   end

   assign pending = pend_q;
   assign clk_out = clk_out_q;
   assign tick    = tick_q;
   assign busy    = busy_q;

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: NUM_CH glitch-free divided clocks from clk.
// Ports: clk, rst_n (async low), bus (clk_div_gen_if.slave).
// Macro: CLK_DIV_GEN_PHASE_EN enables per-channel start delay.
module clk_div_gen
   import clk_div_gen_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int DIV_W   = CFG_W,
   parameter int DEF_DIV = 4
) (
   input logic          clk,
   input logic          rst_n,
   clk_div_gen_if.slave bus
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   if (DIV_W != CFG_W) begin : g_bad_div_w
      $error("DIV_W must equal clk_div_gen_pkg::CFG_W");
   end

   if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
      $error("NUM_CH must be 1..16");
   end

   logic [CH_W:0]     ch_ext;
   logic              ch_ok;
   logic              cfg_ok;
   logic              acc;
   logic              ready;
   ch_cfg_t           wr_cfg;
   logic [NUM_CH-1:0] wr_en;
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] clk_out_w;
   logic [NUM_CH-1:0] tick_w;
   logic [NUM_CH-1:0] busy_w;
   logic              err_q, err_d;

   always_comb begin
      ch_ext = {1'b0, bus.cfg_ch};
      ch_ok  = (ch_ext < (CH_W + 1)'(NUM_CH));
      wr_cfg = '{
         div:   bus.cfg_div,
         high:  bus.cfg_high,
         phase: bus.cfg_phase
      };
      cfg_ok = ch_ok && cfg_is_valid(wr_cfg);
      // Out-of-range targets are accepted only to be rejected.
      ready  = ch_ok ? !pend[bus.cfg_ch] : 1'b1;
      acc    = bus.cfg_valid && ready;
      err_d  = acc && !cfg_ok;
      wr_en  = '0;
      if (acc && cfg_ok) begin
         wr_en[bus.cfg_ch] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_gen_ch #(
         .DEF_DIV (DEF_DIV)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (bus.enable[i]),
         .wr_en   (wr_en[i]),
         .wr_cfg  (wr_cfg),
         .pending (pend[i]),
         .clk_out (clk_out_w[i]),
         .tick    (tick_w[i]),
         .busy    (busy_w[i])
      );
   end

   assign bus.cfg_ready = ready;
   assign bus.cfg_err   = err_q;
   assign bus.clk_out   = clk_out_w;
   assign bus.tick      = tick_w;
   assign bus.busy      = busy_w;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed bench with an expected-output queue for
// clk_div_gen (NUM_CH=4, DIV_W=8, DEF_DIV=4).
module tb_clk_div_gen;

`ifdef CLK_DIV_GEN_PHASE_EN
   localparam bit PH_EN = 1'b1;
   localparam int D_EFF = 2;
`else
   localparam bit PH_EN = 1'b0;
   localparam int D_EFF = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   // entries are {clk_out, tick, busy} after successive edges
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   clk_div_gen_if #(.NUM_CH(4), .DIV_W(8)) bus ();

   clk_div_gen #(
      .NUM_CH  (4),
      .DIV_W   (8),
      .DEF_DIV (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_lead(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({2'b00, (i > 0)});
      end
   endtask

   task automatic push_pat(input int p, input int h,
                           input int n);
      int c;
      for (int i = 0; i < n; i++) begin
         c = i % p;
         exp_q.push_back({(c < h), (c == 0), 1'b1});
      end
   endtask

   task automatic drain1(input int ch, input string tag);
      logic [2:0] e;
      logic [2:0] o;
      step();
      e = exp_q.pop_front();
      o = {bus.clk_out[ch], bus.tick[ch], bus.busy[ch]};
      chk(tag, {29'd0, o}, {29'd0, e});
   endtask

   task automatic drain_all(input int ch, input string tag);
      while (exp_q.size() > 0) drain1(ch, tag);
   endtask

   task automatic wait_tick(input int ch, input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 32 && !seen; i++) begin
         step();
         seen = bus.tick[ch];
      end
      chk(tag, {31'd0, seen}, 32'd1);
   endtask

   task automatic cfg_set(input int ch, input int p,
                          input int h, input int d);
      bus.cfg_valid = 1'b1;
      bus.cfg_ch    = 2'(ch);
      bus.cfg_div   = 8'(p);
      bus.cfg_high  = 8'(h);
      bus.cfg_phase = 8'(d);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.enable    = '0;
      bus.cfg_valid = 1'b0;
      bus.cfg_ch    = '0;
      bus.cfg_div   = '0;
      bus.cfg_high  = '0;
      bus.cfg_phase = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_clk_out", {28'd0, bus.clk_out}, 32'd0);
      chk("rst_tick", {28'd0, bus.tick}, 32'd0);
      chk("rst_busy", {28'd0, bus.busy}, 32'd0);
      chk("rst_cfg_err", {31'd0, bus.cfg_err}, 32'd0);
      chk("rst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
      #3 rst_n = 1'b1;

      // defaults: 1100 repeating, one cycle after enable
      bus.enable[0] = 1'b1;
      push_lead(1);
      push_pat(4, 2, 12);
      drain_all(0, "ch0_default");

      // ch1 P=5 H=1 D=2 on an idle channel
      cfg_set(1, 5, 1, 2);
      chk("ch1_wr_ready", {31'd0, bus.cfg_ready}, 32'd1);
      step();
      bus.cfg_valid = 1'b0;
      chk("ch1_wr_err", {31'd0, bus.cfg_err}, 32'd0);
      bus.enable[1] = 1'b1;
      push_lead(1 + D_EFF);
      push_pat(5, 1, 10);
      drain_all(1, "ch1_p5h1");

      // drop enable[0] in the first high cycle
      wait_tick(0, "ch0_sync_tick");
      bus.enable[0] = 1'b0;
      exp_q.push_back(3'b101);
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b000);
      exp_q.push_back(3'b000);
      drain_all(0, "ch0_stop");

      // live reconfig P=6 H=3 while running at P=4
      bus.enable[0] = 1'b1;
      push_lead(1);
      push_pat(4, 2, 4);
      push_pat(6, 3, 18);
      drain1(0, "ch0_reconf");
      drain1(0, "ch0_reconf");
      cfg_set(0, 6, 3, 0);
      drain1(0, "ch0_reconf");
      bus.cfg_valid = 1'b0;
      chk("reconf_err", {31'd0, bus.cfg_err}, 32'd0);
      chk("reconf_ready_a", {31'd0, bus.cfg_ready}, 32'd0);
      drain1(0, "ch0_reconf");
      chk("reconf_ready_b", {31'd0, bus.cfg_ready}, 32'd0);
      drain1(0, "ch0_reconf");
      chk("reconf_ready_c", {31'd0, bus.cfg_ready}, 32'd1);

      // rejected writes while ch0 keeps its 111000 pattern
      cfg_set(0, 6, 0, 0);
      drain1(0, "ch0_bad_wr");
      chk("err_h0", {31'd0, bus.cfg_err}, 32'd1);
      cfg_set(0, 6, 6, 0);
      drain1(0, "ch0_bad_wr");
      chk("err_h_eq_p", {31'd0, bus.cfg_err}, 32'd1);
      cfg_set(0, 1, 1, 0);
      drain1(0, "ch0_bad_wr");
      chk("err_p1", {31'd0, bus.cfg_err}, 32'd1);
      bus.cfg_valid = 1'b0;
      drain1(0, "ch0_bad_wr");
      chk("err_clear", {31'd0, bus.cfg_err}, 32'd0);
      cfg_set(2, 4, 2, 4);
      drain1(0, "ch0_bad_wr");
      bus.cfg_valid = 1'b0;
      chk("err_phase", {31'd0, bus.cfg_err}, {31'd0, PH_EN});
      drain_all(0, "ch0_p6h3");

      // async reset during a high phase
      bus.enable = 4'b1111;
      wait_tick(0, "ch0_pre_rst_tick");
      chk("pre_rst_high", {31'd0, bus.clk_out[0]}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_clk_out", {28'd0, bus.clk_out}, 32'd0);
      chk("mid_rst_tick", {28'd0, bus.tick}, 32'd0);
      chk("mid_rst_busy", {28'd0, bus.busy}, 32'd0);
      chk("mid_rst_ready", {31'd0, bus.cfg_ready}, 32'd1);
      bus.enable = 4'b0001;
      #1 rst_n = 1'b1;
      push_lead(1);
      push_pat(4, 2, 8);
      drain_all(0, "ch0_after_rst");

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
